// File: rtl/clock_disp_pkg.sv
// Shared constants and types for the multiplexed HH:MM:SS seven-segment driver.
package clock_disp_pkg;

  localparam int NUM_DIGITS = 6;

  // Active-low segment patterns, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    BLINK_NONE = 2'b00,
    BLINK_SEC  = 2'b01,
    BLINK_MIN  = 2'b10,
    BLINK_HR   = 2'b11
  } blink_sel_e;

  typedef struct packed {
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    blink_sel_e blink;
  } snap_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  function automatic bcd_t split_bcd(input logic [5:0] value);
    bcd_t res;
    res.tens = 4'(value / 6'd10);
    res.ones = 4'(value % 6'd10);
    return res;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern; blank overrides dash overrides digit.
module seg7_decode
  import clock_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dash,
  input  logic       blank,
  output logic [6:0] seg
);

  // Pattern lookup with blank/dash priority
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else if (dash) begin
      seg = SEG_DASH;
    end else begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/clock_display_driver.sv
// Six-digit multiplexed clock display: per-frame snapshot, range dashing and field blinking.
module clock_display_driver
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [4:0] i_hr,
  input  logic [1:0] i_blink_sel,
  output logic [5:0] o_an,
  output logic [6:0] o_seg
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
  localparam logic [2:0]         LAST_DIGIT = 3'(NUM_DIGITS - 1);

  logic [SCAN_W-1:0]  scan_cnt_r;
  logic [2:0]         digit_idx_r;
  logic [FRAME_W-1:0] frame_cnt_r;
  logic               blink_phase_r;
  logic               started_r;
  snap_t              snap_r;
  logic [5:0]         an_r;
  logic [6:0]         seg_r;

  logic       tick_s;
  logic       wrap_s;
  logic [5:0] field_val_s;
  logic       field_bad_s;
  logic       field_blink_s;
  bcd_t       bcd_s;
  logic [3:0] digit_s;
  logic [6:0] seg_s;

  assign tick_s = (scan_cnt_r == SCAN_LAST);
  assign wrap_s = tick_s && (digit_idx_r == LAST_DIGIT);

  // Scan timing, digit sequencing, frame snapshot and blink phase
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      scan_cnt_r    <= '0;
      digit_idx_r   <= LAST_DIGIT;
      frame_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
      started_r     <= 1'b0;
      snap_r        <= '0;
    end else begin
      scan_cnt_r <= tick_s ? '0 : scan_cnt_r + SCAN_W'(1);
      if (tick_s) begin
        digit_idx_r <= (digit_idx_r == LAST_DIGIT) ? 3'd0 : digit_idx_r + 3'd1;
      end
      // A frame starts at the 5->0 wrap; everything it shows comes from this capture
      if (wrap_s) begin
        started_r    <= 1'b1;
        snap_r.sec   <= i_sec;
        snap_r.min   <= i_min;
        snap_r.hr    <= i_hr;
        snap_r.blink <= blink_sel_e'(i_blink_sel);
        if (frame_cnt_r == FRAME_LAST) begin
          frame_cnt_r   <= '0;
          blink_phase_r <= ~blink_phase_r;
        end else begin
          frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
        end
      end
    end
  end

  // Select the snapshot field, range status and blink status for the current digit
  always_comb begin
    field_val_s   = 6'd0;
    field_bad_s   = 1'b0;
    field_blink_s = 1'b0;
    case (digit_idx_r)
      3'd0, 3'd1: begin
        field_val_s   = snap_r.sec;
        field_bad_s   = (snap_r.sec > 6'd59);
        field_blink_s = (snap_r.blink == BLINK_SEC);
      end
      3'd2, 3'd3: begin
        field_val_s   = snap_r.min;
        field_bad_s   = (snap_r.min > 6'd59);
        field_blink_s = (snap_r.blink == BLINK_MIN);
      end
      3'd4, 3'd5: begin
        field_val_s   = {1'b0, snap_r.hr};
        field_bad_s   = (snap_r.hr > 5'd23);
        field_blink_s = (snap_r.blink == BLINK_HR);
      end
      default: begin
        field_val_s   = 6'd0;
        field_bad_s   = 1'b0;
        field_blink_s = 1'b0;
      end
    endcase
  end

  assign bcd_s   = split_bcd(field_val_s);
  assign digit_s = digit_idx_r[0] ? bcd_s.tens : bcd_s.ones;

  seg7_decode u_seg7_decode (
    .digit (digit_s),
    .dash  (field_bad_s),
    .blank (field_blink_s & blink_phase_r),
    .seg   (seg_s)
  );

  // Registered anode/segment drive, dark until the first frame has been captured
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      an_r  <= 6'b111111;
      seg_r <= SEG_BLANK;
    end else if (started_r) begin
      an_r  <= ~(6'd1 << digit_idx_r);
      seg_r <= seg_s;
    end else begin
      an_r  <= 6'b111111;
      seg_r <= SEG_BLANK;
    end
  end

  assign o_an  = an_r;
  assign o_seg = seg_r;

endmodule

// File: tb/tb_clock_display_driver.sv
// Directed bench for clock_display_driver with SCAN_DIV=4, BLINK_FRAMES=2.
module tb_clock_display_driver;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;

  logic       clk;
  logic       rstn;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hr;
  logic [1:0] blink_sel;
  logic [5:0] an;
  logic [6:0] seg;

  int n_tests;
  int n_fail;

  clock_display_driver #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_sec       (sec),
    .i_min       (min),
    .i_hr        (hr),
    .i_blink_sel (blink_sel),
    .o_an        (an),
    .o_seg       (seg)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (an,seg)", tag, obs, exp);
    end
  endtask

  // Dark display while the first post-reset scan slot runs
  task automatic check_dark(input string tag, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      check_eq(tag, {19'd0, an, seg}, {19'd0, 6'b111111, SB});
    end
  endtask

  // One full frame, 4 cycles per digit; optionally drive new inputs at sample chg_k
  task automatic check_frame(input string tag,
                             input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2,
                             input logic [6:0] e3, input logic [6:0] e4, input logic [6:0] e5,
                             input int chg_k, input logic [5:0] sec_v, input logic [5:0] min_v,
                             input logic [4:0] hr_v, input logic [1:0] bs_v);
    logic [6:0] e [6];
    logic [5:0] an_exp;
    int d;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4; e[5] = e5;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      d = k / 4;
      an_exp = ~(6'b000001 << d);
      check_eq(tag, {19'd0, an, seg}, {19'd0, an_exp, e[d]});
      if (k == chg_k) begin
        sec = sec_v;
        min = min_v;
        hr = hr_v;
        blink_sel = bs_v;
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    clk = 1'b0;
    rstn = 1'b0;
    sec = 6'd56;
    min = 6'd34;
    hr = 5'd12;
    blink_sel = 2'b00;

    repeat (3) @(negedge clk);
    check_eq("reset", {19'd0, an, seg}, {19'd0, 6'b111111, SB});
    rstn = 1'b1;
    check_dark("pre_first_tick", 4);

    check_frame("f1_12_34_56", S6, S5, S4, S3, S2, S1, -1, 6'd0, 6'd0, 5'd0, 2'b00);
    check_frame("f2_12_34_56", S6, S5, S4, S3, S2, S1, -1, 6'd0, 6'd0, 5'd0, 2'b00);
    // Seconds change while digit 3 is lit; this frame keeps 56
    check_frame("f3_no_tear", S6, S5, S4, S3, S2, S1, 13, 6'd57, 6'd34, 5'd12, 2'b00);
    check_frame("f4_sec57", S7, S5, S4, S3, S2, S1, 2, 6'd57, 6'd60, 5'd24, 2'b00);
    check_frame("f5_dash", S7, S5, SD, SD, SD, SD, 2, 6'd57, 6'd5, 5'd12, 2'b10);
    // Phase went high at the f2 capture, low at f4, high again at f6
    check_frame("f6_blink_off", S7, S5, SB, SB, S2, S1, -1, 6'd0, 6'd0, 5'd0, 2'b00);
    check_frame("f7_blink_off", S7, S5, SB, SB, S2, S1, -1, 6'd0, 6'd0, 5'd0, 2'b00);
    check_frame("f8_blink_on", S7, S5, S5, S0, S2, S1, -1, 6'd0, 6'd0, 5'd0, 2'b00);
    check_frame("f9_blink_on", S7, S5, S5, S0, S2, S1, -1, 6'd0, 6'd0, 5'd0, 2'b00);

    repeat (10) @(negedge clk);
    rstn = 1'b0;
    sec = 6'd0;
    min = 6'd0;
    hr = 5'd0;
    blink_sel = 2'b00;
    @(negedge clk);
    check_eq("midframe_reset", {19'd0, an, seg}, {19'd0, 6'b111111, SB});
    rstn = 1'b1;
    check_dark("restart_dark", 4);

    check_frame("zeros", S0, S0, S0, S0, S0, S0, 2, 6'd59, 6'd59, 5'd23, 2'b00);
    check_frame("max_23_59_59", S9, S5, S9, S5, S3, S2, -1, 6'd0, 6'd0, 5'd0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_display_driver.md
CLOCK_DISPLAY_DRIVER -- requirements
Module: clock_display_driver

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clock cycles per digit scan slot (>=2).
REQ-002 Parameter BLINK_FRAMES, default 64, full 6-digit frames per blink half-period (>=1).
REQ-003 i_clk  input  1  single clock; all state on rising edge.
REQ-004 i_rstn  input  1  reset, synchronous, active-low.
REQ-005 i_sec  input  6  binary seconds from clock core, legal 0..59.
REQ-006 i_min  input  6  binary minutes, legal 0..59.
REQ-007 i_hr  input  5  binary hours, legal 0..23.
REQ-008 i_blink_sel  input  2  field to blink: 00 none, 01 sec, 10 min, 11 hr.
REQ-009 o_an  output  6  digit enables, active-low one-hot; bit0 sec ones, 1 sec tens, 2 min ones, 3 min tens, 4 hr ones, 5 hr tens.
REQ-010 o_seg  output  7  segments gfedcba, active-low.

Function
REQ-011 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; scan tick SHALL assert on the cycle the counter equals SCAN_DIV-1.
REQ-012 Digit index SHALL advance 0,1,2,3,4,5,0,... on each scan tick only.
REQ-013 On the tick where digit index wraps 5->0, i_sec/i_min/i_hr/i_blink_sel SHALL be captured into a frame snapshot; all six digits of a frame SHALL display that snapshot only (no tearing).
REQ-014 Each field SHALL be split to tens = value/10, ones = value%10 from the snapshot; leading zeros SHALL be displayed.
REQ-015 A snapshot field outside its legal range SHALL display dash (g only, o_seg = 7'b0111111) on both its digits.
REQ-016 Digits 0-9 SHALL use standard 7-segment patterns (e.g. 0 = 7'b1000000, 8 = 7'b0000000).
REQ-017 o_an and o_seg SHALL be registered and reflect the current digit index with exactly 1 cycle latency after the index changes.
REQ-018 Frame counter SHALL increment at each snapshot capture and wrap at BLINK_FRAMES, toggling blink phase on wrap.
REQ-019 When blink phase = 1 and snapshot i_blink_sel selects a field, that field's two digits SHALL show o_seg = 7'b1111111 while o_an still enables the digit; other fields unaffected.
REQ-020 A change of i_blink_sel mid-frame SHALL take effect only at the next snapshot.
REQ-021 Exactly one o_an bit SHALL be low at any time after the first post-reset output update.

Reset
REQ-022 While i_rstn = 0 at a clock edge: scan counter 0, digit index 5, frame counter 0, blink phase 0, snapshot all zero, o_an = 6'b111111, o_seg = 7'b1111111.
REQ-023 Reset asserted mid-frame SHALL override all activity at that edge; after release, first scan tick SHALL select digit 0 and capture a fresh snapshot.

Structure
REQ-024 Shared package clock_disp_pkg SHALL hold digit count (6), segment pattern constants (digits 0-9, dash, blank) and the blink-select encoding.
REQ-025 One sub-module seg7_decode (4-bit digit plus dash/blank controls -> 7-bit active-low segments) SHALL be instantiated once on the output path.
REQ-026 Divide/modulo by 10 SHALL be combinational on 6-bit values; no multi-cycle divider.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-027 Reset, release, hold inputs 12:34:56 -> o_an stays 111111 until first tick+1, then digits sec ones..hr tens show 6,5,4,3,2,1, each for 4 cycles, cycling.
REQ-028 Change i_sec 56->57 while digit 3 is active -> digits 4,5 of current frame unchanged; next frame digit 0 shows 7.
REQ-029 i_hr=24, i_min=60 -> hr and min digits show 7'b0111111; sec digits normal.
REQ-030 i_blink_sel=10, min=05 -> min digits display 5,0 for 2 frames, blank 7'b1111111 for 2 frames with o_an[2]/o_an[3] still pulsing low, repeating.
REQ-031 Assert i_rstn=0 for one cycle mid-frame -> next cycle o_an=111111, o_seg=1111111; display restarts at digit 0 after SCAN_DIV cycles.
REQ-032 Boundary values 00:00:00 and 23:59:59 -> all digits correct, leading zeros shown, one-hot o_an checked every cycle.
